// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with debounce. It drives one
//               active-low column at a time, samples the synchronized row
//               lines, debounces a press, and then reports it for a single
//               cycle. After a report it waits for a debounced release before
//               it scans again, so a held key is reported only once.
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               rows_n[3:0]- active-low row sense lines (asynchronous)
//               col_n[3:0] - active-low one-hot column drive (registered)
//               key_out[4:0]- key code (col*4+row) in the report cycle,
//                             IDLE_CODE at all other times (registered)
//               key_valid  - high only in the report cycle (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DEB_CYCLES = 8,
  parameter logic [4:0]  IDLE_CODE  = 5'd21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows_n,
  output logic [3:0] col_n,
  output logic [4:0] key_out,
  output logic       key_valid
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES);
  localparam logic [3:0]        ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [1:0]        col_idx_q,  col_idx_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
  logic [3:0]        cap_rows_q, cap_rows_d;
  logic [3:0]        cap_code_q, cap_code_d;
  logic [3:0]        col_n_q,    col_n_d;
  logic [4:0]        key_out_q,  key_out_d;
  logic              key_valid_q, key_valid_d;

  // Two-flop synchronizer; rs_q is the only view of the rows used below.
  logic [3:0]        sync1_q;
  logic [3:0]        rs_q;

  // Combinational helpers
  logic [1:0]        row_idx_w;
  logic [DEB_W-1:0]  deb_next_w;

  // --------------------------------------------------------------------------
  // Row synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= ROWS_IDLE;
      rs_q    <= ROWS_IDLE;
    end else begin
      sync1_q <= rows_n;
      rs_q    <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Lowest-index active row wins when several rows are low. The loop runs
  // from high to low so the last assignment is the lowest index.
  // --------------------------------------------------------------------------
  always_comb begin
    row_idx_w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) begin
        row_idx_w = 2'(i);
      end
    end
  end

  // The stored counter never exceeds DEB_CYCLES-1; the terminal value only
  // exists on this wire, which is compared and then discarded.
  assign deb_next_w = deb_cnt_q + DEB_W'(1);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    cap_rows_d = cap_rows_q;
    cap_code_d = cap_code_q;

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (rs_q == ROWS_IDLE) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            // Column stays frozen on the pressed key from here on.
            cap_rows_d = rs_q;
            cap_code_d = {col_idx_q, row_idx_w};
            deb_cnt_d  = '0;
            state_d    = DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      DEBOUNCE: begin
        if (rs_q == cap_rows_q) begin
          if (deb_next_w == DEB_LAST) begin
            deb_cnt_d = '0;
            state_d   = REPORT;
          end else begin
            deb_cnt_d = deb_next_w;
          end
        end else begin
          // Bounce: give up on this key and move on to the next column.
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
          state_d    = SCAN;
        end
      end

      REPORT: begin
        deb_cnt_d = '0;
        state_d   = RELEASE;
      end

      RELEASE: begin
        if (rs_q == ROWS_IDLE) begin
          if (deb_next_w == DEB_LAST) begin
            deb_cnt_d  = '0;
            scan_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            deb_cnt_d = deb_next_w;
          end
        end else begin
          // Any key still down (including a second key) restarts the wait.
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    // Outputs are registered so they line up with the REPORT state itself.
    key_valid_d = (state_d == REPORT);
    key_out_d   = (state_d == REPORT) ? {1'b0, cap_code_d} : IDLE_CODE;
    col_n_d     = ~(4'b0001 << col_idx_d);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      cap_rows_q  <= ROWS_IDLE;
      cap_code_q  <= 4'd0;
      col_n_q     <= 4'b1110;
      key_out_q   <= IDLE_CODE;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      cap_rows_q  <= cap_rows_d;
      cap_code_q  <= cap_code_d;
      col_n_q     <= col_n_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A 4x4 key matrix
//               model turns pressed keys plus the driven column into rows_n.
//               Expected report codes are queued when a press is driven and
//               popped by a monitor whenever key_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEB_CYCLES = 8;
  localparam logic [4:0]  IDLE_CODE  = 5'd21;
  localparam int          LAT_MIN    = 2 + DEB_CYCLES;
  localparam int          LAT_MAX    = 2 + SCAN_DIV + DEB_CYCLES + 1;

  logic       clk;
  logic       rst;
  logic [3:0] rows_n;
  logic [3:0] col_n;
  logic [4:0] key_out;
  logic       key_valid;

  logic [15:0] keys;       // keys[col*4+row] = 1 means held down
  logic [4:0]  exp_q[$];   // scoreboard of expected report codes
  logic        mon_en;
  int          checks;
  int          errors;
  int          reports_seen;

  keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .IDLE_CODE (IDLE_CODE)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rows_n   (rows_n),
    .col_n    (col_n),
    .key_out  (key_out),
    .key_valid(key_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    rows_n = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (col_n[c] === 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) rows_n[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Wait (bounded) for every queued report to be consumed by the monitor.
  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Monitor: every report must match the scoreboard head; otherwise idle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("col_onehot", $countones(~col_n), 1);
      if (key_valid === 1'b1) begin
        reports_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_report", key_out, IDLE_CODE);
          check("unexpected_valid", key_valid, 0);
        end else begin
          check("report_code", key_out, exp_q.pop_front());
        end
      end else begin
        check("idle_valid", key_valid, 0);
        check("idle_code", key_out, IDLE_CODE);
      end
    end
  end

  initial begin
    int         lat;
    logic [3:0] exp_col;

    checks       = 0;
    errors       = 0;
    reports_seen = 0;
    mon_en       = 1'b0;
    keys         = '0;
    rst          = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", col_n, 4'b1110);
    check("rst_key_out", key_out, IDLE_CODE);
    check("rst_valid", key_valid, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle scanning: four cycles per column, wrapping 3 -> 0
    for (int n = 0; n < 40; n++) begin
      exp_col = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      check("scan_col", col_n, exp_col);
      step(1);
    end

    // Key 9 pressed as column 2 becomes active; latency, single report
    for (int i = 0; i < 20; i++) begin
      if (col_n === 4'b1011) break;
      step(1);
    end
    check("col2_reached", col_n, 4'b1011);
    keys[9] = 1'b1;
    exp_q.push_back(5'd9);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      lat++;
      if (key_valid === 1'b1) break;
    end
    check("lat_min", (lat >= LAT_MIN), 1);
    check("lat_max", (lat <= LAT_MAX), 1);
    step(50 - lat);
    check("held_col_frozen", col_n, 4'b1011);
    keys[9] = 1'b0;
    step(40);
    check("key9_drained", exp_q.size(), 0);

    // Bouncing key 0: no report while toggling, one after it settles
    for (int i = 0; i < 10; i++) begin
      keys[0] = (i % 2 == 0);
      step(3);
    end
    keys[0] = 1'b1;
    exp_q.push_back(5'd0);
    wait_drain("key0_report", 100);
    keys[0] = 1'b0;
    step(30);

    // Key 5 held, key 6 added meanwhile, both released, then key 6 alone
    keys[5] = 1'b1;
    exp_q.push_back(5'd5);
    wait_drain("key5_report", 100);
    keys[6] = 1'b1;
    step(40);
    keys[5] = 1'b0;
    keys[6] = 1'b0;
    step(30);
    keys[6] = 1'b1;
    exp_q.push_back(5'd6);
    wait_drain("key6_report", 100);
    keys[6] = 1'b0;
    step(30);

    // Rows 1 and 3 together in column 3: lowest row wins
    keys[13] = 1'b1;
    keys[15] = 1'b1;
    exp_q.push_back(5'd13);
    wait_drain("key13_report", 100);
    keys[13] = 1'b0;
    keys[15] = 1'b0;
    step(30);

    // Reset during the report cycle of key 15
    keys[15] = 1'b1;
    exp_q.push_back(5'd15);
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (key_valid === 1'b1) break;
    end
    check("key15_report_seen", key_valid, 1);
    rst      = 1'b1;
    keys[15] = 1'b0;
    step(1);
    check("rpt_rst_valid", key_valid, 0);
    check("rpt_rst_key_out", key_out, IDLE_CODE);
    check("rpt_rst_col", col_n, 4'b1110);
    rst = 1'b0;
    step(30);

    check("total_reports", reports_seen, 6);
    check("queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving the clock cycles each column stays driven during scanning (minimum 3).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 8, giving the consecutive stable cycles required for press and release debounce (minimum 2).
REQ-003 The block SHALL have parameter IDLE_CODE, default 5'd21, the code driven on key_out when no key event is reported.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port rows_n, input, 4 bits: active-low row sense lines from a 4x4 matrix keypad, asynchronous to clk.
REQ-007 Port col_n, output, 4 bits: active-low one-hot column drive; exactly one bit is low at all times.
REQ-008 Port key_out, output, 5 bits: key code feed for the downstream lock FSM; IDLE_CODE except during the single report cycle.
REQ-009 Port key_valid, output, 1 bit: high only in the report cycle.

Function
REQ-010 rows_n SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rs.
REQ-011 Key code SHALL be col_idx*4 + row_idx (0..15), where col_idx is the low bit of col_n and row_idx is the lowest-index low bit of rs; multiple rows low SHALL resolve to the lowest row index.
REQ-012 FSM states: SCAN, DEBOUNCE, REPORT, RELEASE.
REQ-013 SCAN: a cycle counter SHALL count 0..SCAN_DIV-1 per column; on the last count, if rs == 4'b1111 the column SHALL rotate (col_idx+1, wrapping 3->0) and the counter SHALL clear; otherwise the FSM SHALL capture rs and col_idx and enter DEBOUNCE with the column frozen.
REQ-014 DEBOUNCE: each cycle rs equals the captured pattern, the debounce counter SHALL increment; any mismatch SHALL return to SCAN, clearing counters and advancing the column; reaching DEB_CYCLES SHALL enter REPORT.
REQ-015 REPORT: for exactly one cycle, key_out SHALL equal the captured code and key_valid SHALL be 1; the next state SHALL be RELEASE.
REQ-016 RELEASE: the column SHALL stay frozen; the counter SHALL count consecutive cycles with rs == 4'b1111 and clear on any non-1111 cycle; reaching DEB_CYCLES SHALL return to SCAN with the column advanced.
REQ-017 A held key SHALL produce exactly one report regardless of hold duration; a second key pressed while the first is held SHALL NOT be reported.
REQ-018 key_out and key_valid SHALL be registered outputs; outside REPORT, key_out SHALL equal IDLE_CODE and key_valid SHALL be 0.
REQ-019 Press-to-report latency, measured from the rows_n change while the matching column is driven, SHALL be 2 (sync) + at most SCAN_DIV + DEB_CYCLES + 1 cycles.
REQ-020 Counter widths SHALL cover the parameter values without wrap-around; no counter SHALL increment past its terminal value.

Reset
REQ-021 While rst is high at a clock edge: state SCAN, col_n = 4'b1110, counters 0, synchronizer flops 4'b1111, key_out = IDLE_CODE, key_valid = 0.
REQ-022 Reset asserted in any state, including REPORT, SHALL override that cycle's behaviour; no pending report SHALL survive reset.

Verification
REQ-023 Reset, rows_n = 4'b1111 for 40 cycles -> col_n cycles 1110, 1101, 1011, 0111, 1110 with 4 cycles per step; key_out stays 21; key_valid stays 0.
REQ-024 Press row 1 while col_n = 4'b1011 (col 2), hold for 50 cycles, then release -> exactly one key_valid pulse with key_out = 9, 21 in every other cycle.
REQ-025 Bounce: row 0 at col 0 toggles every 3 cycles for 30 cycles, then holds low -> no report during the toggling; one report with key_out = 0 after 8 stable cycles.
REQ-026 Hold key 5, press key 6 while it is held, release both, then press 6 alone -> only codes 5 and then 6 are reported, one pulse each.
REQ-027 rst asserted in the REPORT cycle of key 15 -> key_valid = 0 and key_out = 21 on the following cycle; col_n = 4'b1110.
REQ-028 Rows 1 and 3 pressed together at col 3 -> key_out = 13 (lowest row wins).
